// File: rtl/uart_rx_param.sv
// Oversampling serial receiver: LSB-first frames with optional parity and 1-2 stop bits,
// delivered through a valid/ready holding register with parity, framing and overrun flags.
//
// Handshake: rx_valid stays high with rx_data/flags stable until an edge where
// rx_valid && rx_ready; that edge consumes the word. Data and flags are held after consumption.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_tick,
   input  logic                 din,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             sync_q, sync_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   prev_q, prev_d;
   logic                   par_bad_q, par_bad_d;
   logic                   stop_bad_q, stop_bad_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   logic dsync;
   logic complete;
   logic accept;

   assign dsync = sync_q[1];

   always_comb begin
      sync_d     = {sync_q[0], din};
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      prev_d     = prev_q;
      par_bad_d  = par_bad_q;
      stop_bad_d = stop_bad_q;
      complete   = 1'b0;

      if (sample_tick) begin
         case (state_q)
            S_IDLE: begin
               prev_d = dsync;
               if (prev_q && !dsync) begin
                  state_d = S_START;
                  tick_d  = '0;
               end
            end
            S_START: begin
               if (tick_q == HALF_M1) begin
                  if (!dsync) begin
                     state_d = S_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = S_IDLE;
                     prev_d  = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_DATA: begin
               if (tick_q == FULL_M1) begin
                  tick_d  = '0;
                  shift_d = {dsync, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == LAST_DATA) begin
                     bit_d      = '0;
                     par_bad_d  = 1'b0;
                     stop_bad_d = 1'b0;
                     state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (tick_q == FULL_M1) begin
                  tick_d    = '0;
                  par_bad_d = ((^shift_q) ^ dsync) != (PARITY_ODD != 0);
                  state_d   = S_STOP;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_STOP: begin
               if (tick_q == FULL_M1) begin
                  tick_d     = '0;
                  stop_bad_d = stop_bad_q | ~dsync;
                  if (bit_q == LAST_STOP) begin
                     complete = 1'b1;
                     state_d  = S_IDLE;
                     // A bad stop leaves the edge detector disarmed until the line is seen high.
                     prev_d   = ~(stop_bad_q | ~dsync);
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      accept  = valid_q && rx_ready;
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
      if (complete) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            perr_d  = par_bad_q;
            ferr_d  = stop_bad_d;
            valid_d = 1'b1;
            if (accept) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sync_q     <= 2'b11;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         prev_q     <= 1'b0;
         par_bad_q  <= 1'b0;
         stop_bad_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         prev_q     <= prev_d;
         par_bad_q  <= par_bad_d;
         stop_bad_q <= stop_bad_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8N1, and 8 data + even parity + 2 stop) driven with
// directed and random frames; expected words come from a frame-level model in exp queues.
module tb_uart_rx_param;

   localparam int DB       = 8;
   localparam int OS       = 16;
   localparam int TICK_DIV = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_tick = 1'b0;
   logic          din_a = 1'b1, din_b = 1'b1;
   logic          rdy_a = 1'b1, rdy_b = 1'b1;
   logic [DB-1:0] data_a, data_b;
   logic          valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

   int            n_checks = 0;
   int            n_fail = 0;
   int            tick_div = 0;
   logic [9:0]    exp_a[$];
   logic [9:0]    exp_b[$];

   uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .din(din_a),
      .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rdy_a),
      .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a));

   uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .din(din_b),
      .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rdy_b),
      .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b));

   // Clock and tick generation: one tick every TICK_DIV clocks, changed just after the rising edge.
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick_div    = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
         sample_tick = (tick_div == 0);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted word must match the oldest expected word of its instance.
   always @(negedge clk) begin
      if (rst_n && valid_a && rdy_a) begin
         check("a_word_expected", 32'(exp_a.size() != 0), 32'd1);
         if (exp_a.size() != 0)
            check("a_word", {22'd0, ferr_a, perr_a, data_a}, {22'd0, exp_a.pop_front()});
      end
      if (rst_n && valid_b && rdy_b) begin
         check("b_word_expected", 32'(exp_b.size() != 0), 32'd1);
         if (exp_b.size() != 0)
            check("b_word", {22'd0, ferr_b, perr_b, data_b}, {22'd0, exp_b.pop_front()});
      end
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!sample_tick) @(posedge clk);
      end
   endtask

   task automatic set_din(input bit inst, input bit v);
      if (inst) din_b = v;
      else din_a = v;
   endtask

   task automatic idle(input int n);
      #1;
      din_a = 1'b1;
      din_b = 1'b1;
      wait_ticks(n);
   endtask

   // Drives one frame bit by bit, each bit held OS ticks. The receiver samples 9 ticks into
   // each bit (detection tick plus half a bit), so the last sample lands 9 ticks into the final bit.
   task automatic send_frame(input bit inst, input logic [7:0] data, input bit pbit,
                             input logic [1:0] stop, input bit push, input bit chk_lat);
      bit   bits[$];
      logic fe, pe;
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(data[i]);
      if (inst) begin
         bits.push_back(pbit);
         bits.push_back(stop[0]);
         bits.push_back(stop[1]);
         pe = (^data) ^ pbit;
         fe = ~(stop[0] & stop[1]);
      end else begin
         bits.push_back(stop[0]);
         pe = 1'b0;
         fe = ~stop[0];
      end
      if (push) begin
         if (inst) exp_b.push_back({fe, pe, data});
         else exp_a.push_back({fe, pe, data});
      end
      wait_ticks(1);
      for (int i = 0; i < bits.size(); i++) begin
         #1;
         set_din(inst, bits[i]);
         if (i < bits.size() - 1) begin
            wait_ticks(OS);
         end else begin
            wait_ticks(OS / 2);
            if (chk_lat) begin
               @(negedge clk);
               while (!sample_tick) @(negedge clk);
               check("latency_before", 32'(inst ? valid_b : valid_a), 32'd0);
               @(negedge clk);
               check("latency_after", 32'(inst ? valid_b : valid_a), 32'd1);
            end else begin
               wait_ticks(1);
            end
            wait_ticks(OS / 2 - 1);
         end
      end
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] abort_d;
      logic [1:0] rs;
      bit         ri;

      // Reset state
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_a", {20'd0, data_a, valid_a, perr_a, ferr_a, ovr_a}, 32'd0);
      check("reset_b", {20'd0, data_b, valid_b, perr_b, ferr_b, ovr_b}, 32'd0);
      rst_n = 1'b1;
      wait_ticks(20);

      // Basic 8N1 word with the consumer always ready
      send_frame(1'b0, 8'hA5, 1'b0, 2'b11, 1'b1, 1'b1);
      idle(8);
      check("a5_single_pulse", 32'(valid_a), 32'd0);

      // Overrun: two frames while the consumer is stalled
      rdy_a = 1'b0;
      send_frame(1'b0, 8'h3C, 1'b0, 2'b11, 1'b0, 1'b1);
      idle(4);
      check("ovr_first_valid", 32'(valid_a), 32'd1);
      check("ovr_first_flag", 32'(ovr_a), 32'd0);
      send_frame(1'b0, 8'hC3, 1'b0, 2'b11, 1'b0, 1'b0);
      idle(4);
      check("ovr_valid", 32'(valid_a), 32'd1);
      check("ovr_data", 32'(data_a), 32'h3C);
      check("ovr_flag", 32'(ovr_a), 32'd1);
      check("ovr_errs", {30'd0, perr_a, ferr_a}, 32'd0);
      exp_a.push_back({2'b00, 8'h3C});
      #1 rdy_a = 1'b1;
      @(posedge clk);
      #1 rdy_a = 1'b0;
      @(negedge clk);
      check("ovr_accept_valid", 32'(valid_a), 32'd0);
      check("ovr_accept_flag", 32'(ovr_a), 32'd0);
      check("ovr_accept_data", 32'(data_a), 32'h3C);
      rdy_a = 1'b1;

      // Even parity: correct and wrong parity bits; both words delivered
      send_frame(1'b1, 8'h07, 1'b1, 2'b11, 1'b1, 1'b1);
      idle(8);
      send_frame(1'b1, 8'h07, 1'b0, 2'b11, 1'b1, 1'b1);
      idle(8);
      check("par_err_held", 32'(perr_b), 32'd1);
      // Second stop bit low on the two-stop instance
      send_frame(1'b1, 8'h9E, 1'b0, 2'b01, 1'b1, 1'b1);
      idle(8);

      // Framing error then line held low: no new frame until the line returns high
      send_frame(1'b0, 8'h55, 1'b0, 2'b00, 1'b1, 1'b1);
      wait_ticks(3 * OS);
      check("ferr_no_restart", 32'(valid_a), 32'd0);
      check("ferr_held", 32'(ferr_a), 32'd1);
      check("ferr_data_held", 32'(data_a), 32'h55);
      idle(8);
      send_frame(1'b0, 8'h6B, 1'b0, 2'b11, 1'b1, 1'b1);
      idle(8);

      // Glitch shorter than half a bit is rejected by START
      #1 din_a = 1'b0;
      wait_ticks(4);
      #1 din_a = 1'b1;
      wait_ticks(24);
      check("glitch_no_word", 32'(valid_a), 32'd0);
      check("glitch_no_pending", 32'(exp_a.size()), 32'd0);
      send_frame(1'b0, 8'h81, 1'b0, 2'b11, 1'b1, 1'b1);
      idle(8);

      // Random frames on both instances
      for (int n = 0; n < 12; n++) begin
         ri = 1'($urandom_range(0, 1));
         rd = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         send_frame(ri, rd, 1'($urandom_range(0, 1)), rs, 1'b1, 1'b1);
         idle(8);
      end

      // Reset during data bit 4 abandons the frame
      abort_d = 8'($urandom_range(0, 255));
      wait_ticks(1);
      #1 din_a = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 4; i++) begin
         #1 din_a = abort_d[i];
         wait_ticks(OS);
      end
      #1 din_a = abort_d[4];
      wait_ticks(5);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_a", {20'd0, data_a, valid_a, perr_a, ferr_a, ovr_a}, 32'd0);
      check("midreset_b", {20'd0, data_b, valid_b, perr_b, ferr_b, ovr_b}, 32'd0);
      din_a = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(20);
      check("midreset_no_word", 32'(valid_a), 32'd0);
      send_frame(1'b0, 8'h12, 1'b0, 2'b11, 1'b1, 1'b1);
      idle(8);
      check("post_reset_data", 32'(data_a), 32'h12);

      check("a_drained", 32'(exp_a.size()), 32'd0);
      check("b_drained", 32'(exp_b.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
